// File: rtl/adder_tree_collector.sv
// adder_tree_collector: gathers a serial valid/ready sample stream into one INPUTS_NUM-wide
// vector for a pipelined adder tree. Short vectors (early s_last) are zero-padded through a
// per-slot mask. A TREE_LATENCY-deep delay line flags when the tree output holds the sum.
// Build option: define COLLECTOR_DOUBLE_BUFFER_EN for ping-pong banks (full rate); the default
// build uses a single bank with a COLLECT/PRESENT FSM.
module adder_tree_collector #(
  parameter int unsigned INPUTS_NUM   = 128,
  parameter int unsigned IDATA_WIDTH  = 24,
  parameter int unsigned TREE_LATENCY = $clog2(INPUTS_NUM),
  parameter int unsigned CNT_W        = $clog2(INPUTS_NUM + 1)
) (
  input  logic                                  i_clk,
  input  logic                                  i_reset,
  input  logic                                  i_s_valid,
  output logic                                  o_s_ready,
  input  logic [IDATA_WIDTH-1:0]                i_s_data,
  input  logic                                  i_s_last,
  output logic [INPUTS_NUM-1:0][IDATA_WIDTH-1:0] o_vec_data,
  output logic [CNT_W-1:0]                      o_vec_count,
  output logic                                  o_vec_valid,
  input  logic                                  i_vec_ready,
  output logic                                  o_tree_valid
);

  localparam logic [CNT_W-1:0] LastIdx = CNT_W'(INPUTS_NUM - 1);

  logic [CNT_W-1:0]        r_wr_idx;
  logic [TREE_LATENCY-1:0] r_tree_sr;
  logic                    w_s_accept;
  logic                    w_complete;
  logic                    w_vec_accept;

  assign w_s_accept   = i_s_valid && o_s_ready;
  // s_last on the final slot coincides with the natural end, so no empty vector follows
  assign w_complete   = w_s_accept && (i_s_last || (r_wr_idx == LastIdx));
  assign w_vec_accept = o_vec_valid && i_vec_ready;

  // Write index: advances per accepted sample, wraps to 0 when a vector completes
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_idx <= '0;
    end else if (w_complete) begin
      r_wr_idx <= '0;
    end else if (w_s_accept) begin
      r_wr_idx <= r_wr_idx + CNT_W'(1);
    end
  end

  // Delay line: acceptance pulse emerges TREE_LATENCY cycles later as tree_valid
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_tree_sr <= '0;
    end else begin
      r_tree_sr <= (r_tree_sr << 1) | TREE_LATENCY'(w_vec_accept);
    end
  end

  assign o_tree_valid = r_tree_sr[TREE_LATENCY-1];

`ifdef COLLECTOR_DOUBLE_BUFFER_EN

  logic [IDATA_WIDTH-1:0]       r_bank [2][INPUTS_NUM];
  logic [1:0][INPUTS_NUM-1:0]   r_mask;
  logic [CNT_W-1:0]             r_cnt [2];
  logic [1:0]                   r_full;     // bank completed and not yet taken downstream
  logic                         r_wr_bank;
  logic                         r_rd_bank;

  // Stall input only when the write bank still holds an untaken vector (both banks busy)
  assign o_s_ready   = !i_reset && !r_full[r_wr_bank];
  assign o_vec_valid = r_full[r_rd_bank];
  assign o_vec_count = r_cnt[r_rd_bank];

  // Bank fill, completion and release; banks are presented in completion order
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_full    <= '0;
      r_mask    <= '0;
      r_cnt[0]  <= '0;
      r_cnt[1]  <= '0;
      r_wr_bank <= 1'b0;
      r_rd_bank <= 1'b0;
    end else begin
      if (w_vec_accept) begin
        r_full[r_rd_bank] <= 1'b0;
        r_mask[r_rd_bank] <= '0;
        r_rd_bank         <= ~r_rd_bank;
      end
      if (w_s_accept) begin
        for (int i = 0; i < int'(INPUTS_NUM); i++) begin
          if (r_wr_idx == CNT_W'(i)) begin
            r_bank[r_wr_bank][i] <= i_s_data;
            r_mask[r_wr_bank][i] <= 1'b1;
          end
        end
        if (w_complete) begin
          r_full[r_wr_bank] <= 1'b1;
          r_cnt[r_wr_bank]  <= r_wr_idx + CNT_W'(1);
          r_wr_bank         <= ~r_wr_bank;
        end
      end
    end
  end

  // Masked view of the presenting bank; unwritten slots read as zero
  always_comb begin
    o_vec_data = '0;
    for (int i = 0; i < int'(INPUTS_NUM); i++) begin
      o_vec_data[i] = r_mask[r_rd_bank][i] ? r_bank[r_rd_bank][i] : '0;
    end
  end

`else

  typedef enum logic [0:0] {StCollect, StPresent} state_e;

  state_e                 r_state;
  state_e                 w_state_d;
  logic [IDATA_WIDTH-1:0] r_bank [INPUTS_NUM];
  logic [INPUTS_NUM-1:0]  r_mask;
  logic [CNT_W-1:0]       r_vec_count;

  assign o_s_ready   = !i_reset && (r_state == StCollect);
  assign o_vec_valid = (r_state == StPresent);
  assign o_vec_count = r_vec_count;

  // FSM state register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= StCollect;
    end else begin
      r_state <= w_state_d;
    end
  end

  // FSM next state: collect until completion, present until taken
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StCollect: if (w_complete) w_state_d = StPresent;
      StPresent: if (i_vec_ready) w_state_d = StCollect;
      default:   w_state_d = StCollect;
    endcase
  end

  // Sample bank and padding mask; the mask clears once the vector has been taken
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_mask      <= '0;
      r_vec_count <= '0;
    end else begin
      if (w_vec_accept) begin
        r_mask <= '0;
      end
      if (w_s_accept) begin
        for (int i = 0; i < int'(INPUTS_NUM); i++) begin
          if (r_wr_idx == CNT_W'(i)) begin
            r_bank[i] <= i_s_data;
            r_mask[i] <= 1'b1;
          end
        end
        if (w_complete) begin
          r_vec_count <= r_wr_idx + CNT_W'(1);
        end
      end
    end
  end

  // Masked view of the bank; unwritten slots read as zero
  always_comb begin
    o_vec_data = '0;
    for (int i = 0; i < int'(INPUTS_NUM); i++) begin
      o_vec_data[i] = r_mask[i] ? r_bank[i] : '0;
    end
  end

`endif

endmodule

// File: tb/tb_adder_tree_collector.sv
// Scoreboard bench for adder_tree_collector (INPUTS_NUM=5, IDATA_WIDTH=8, TREE_LATENCY=3).
// Expected vectors are built from the accepted sample stream; a negedge monitor compares.
module tb_adder_tree_collector;

  localparam int unsigned N  = 5;
  localparam int unsigned W  = 8;
  localparam int unsigned L  = 3;
  localparam int unsigned CW = 3;
`ifdef COLLECTOR_DOUBLE_BUFFER_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  typedef struct packed {
    logic [N-1:0][W-1:0] data;
    logic [CW-1:0]       cnt;
  } vec_t;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                s_valid = 1'b0;
  logic                s_last = 1'b0;
  logic [W-1:0]        s_data = '0;
  logic                vec_ready = 1'b0;
  logic                s_ready;
  logic                vec_valid;
  logic                tree_valid;
  logic [N-1:0][W-1:0] vec_data;
  logic [CW-1:0]       vec_count;

  vec_t         exp_q[$];
  int           tq[$];
  logic [W-1:0] cur[$];
  int           n_checks = 0;
  int           n_pass = 0;
  int           cyc = 0;
  bit           rand_ready = 1'b0;
  bit           fixed_ready = 1'b1;
  bit           stalled = 1'b0;
  vec_t         held;

  adder_tree_collector #(
    .INPUTS_NUM  (N),
    .IDATA_WIDTH (W),
    .TREE_LATENCY(L),
    .CNT_W       (CW)
  ) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_s_valid   (s_valid),
    .o_s_ready   (s_ready),
    .i_s_data    (s_data),
    .i_s_last    (s_last),
    .o_vec_data  (vec_data),
    .o_vec_count (vec_count),
    .o_vec_valid (vec_valid),
    .i_vec_ready (vec_ready),
    .o_tree_valid(tree_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Downstream ready: fixed level or random per cycle
  initial begin
    forever begin
      @(posedge clk);
      #2;
      vec_ready = rand_ready ? 1'($urandom_range(0, 1)) : fixed_ready;
    end
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    vec_t e;
    bit   exp_tv;
    if (reset) begin
      exp_q.delete();
      tq.delete();
      cur.delete();
      stalled = 1'b0;
    end else begin
      chk("s_ready", s_ready, exp_q.size() < CAP);
      chk("vec_valid", vec_valid, exp_q.size() > 0);
      exp_tv = (tq.size() > 0) && (tq[0] == cyc);
      if (exp_tv) void'(tq.pop_front());
      chk("tree_valid", tree_valid, exp_tv);
      if (stalled) begin
        chk("hold_data", vec_data, held.data);
        chk("hold_count", vec_count, held.cnt);
      end
      if (exp_q.size() > 0 && vec_ready) begin
        e = exp_q.pop_front();
        chk("vec_data", vec_data, e.data);
        chk("vec_count", vec_count, e.cnt);
        tq.push_back(cyc + int'(L));
      end
      if (s_valid && s_ready) begin
        cur.push_back(s_data);
        if (cur.size() == N || s_last) begin
          e.data = '0;
          for (int i = 0; i < cur.size(); i++) e.data[i] = cur[i];
          e.cnt = CW'(cur.size());
          exp_q.push_back(e);
          cur.delete();
        end
      end
      stalled   = vec_valid && !vec_ready;
      held.data = vec_data;
      held.cnt  = vec_count;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] d, input logic last);
    int t = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    @(negedge clk);
    while (!s_ready && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk("s_ready_wait", s_ready, 1'b1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    @(negedge clk);
    chk({tag, "_s_ready"}, s_ready, 1'b0);
    chk({tag, "_vec_valid"}, vec_valid, 1'b0);
    chk({tag, "_tree_valid"}, tree_valid, 1'b0);
    chk({tag, "_vec_count"}, vec_count, '0);
    chk({tag, "_vec_data"}, vec_data, '0);
  endtask

  initial begin
    int t;
    repeat (2) @(posedge clk);
    chk_reset_outputs("rst");
    @(posedge clk);
    #1 reset = 1'b0;

    // Full vector 1..5
    for (int i = 1; i <= 5; i++) send(W'(i), 1'b0);
    idle(6);

    // Short vector 7,9 with s_last on 9
    send(8'd7, 1'b0);
    send(8'd9, 1'b1);
    idle(6);

    // Backpressure: hold vec_ready low for 4 cycles after vec_valid
    fixed_ready = 1'b0;
    for (int i = 11; i <= 15; i++) send(W'(i), 1'b0);
    t = 0;
    while (!vec_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("bp_vec_valid", vec_valid, 1'b1);
    idle(4);
    fixed_ready = 1'b1;
    idle(6);

    // Reset after 3 samples, then a clean full vector
    for (int i = 21; i <= 23; i++) send(W'(i), 1'b0);
    reset = 1'b1;
    @(posedge clk);
    chk_reset_outputs("midrst");
    @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 31; i <= 35; i++) send(W'(i), 1'b0);
    idle(6);

    // s_last on slot 4 matches the natural end
    for (int i = 1; i <= 4; i++) send(W'(i), 1'b0);
    send(8'd5, 1'b1);
    idle(6);

    // Continuous stream with vec_ready tied high
    for (int i = 0; i < 20; i++) send(W'($urandom_range(1, 255)), 1'b0);
    idle(8);

    // Random traffic with random backpressure
    rand_ready = 1'b1;
    for (int i = 0; i < 150; i++) begin
      idle(int'($urandom_range(0, 2)));
      send(W'($urandom), ($urandom_range(0, 3) == 0) || (i == 149));
    end
    rand_ready = 1'b0;
    fixed_ready = 1'b1;

    t = 0;
    while ((exp_q.size() > 0 || tq.size() > 0) && t < 100) begin
      @(posedge clk);
      t++;
    end
    @(negedge clk);
    chk("drain_left", exp_q.size() + tq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
